mem_stage_hs: RTL and testbench

Y86 memory-access stage with valid/ready handshakes on both pipeline sides and a request/acknowledge handshake to data memory, so memory can take any number of cycles.
Decodes icode to choose read or write, the address and the write data. Captures read data, and flags misaligned, errored or timed-out accesses through a status code.
Sits between execute and write-back and replaces the purely combinational memory stage.

---
 rtl/mem_stage_hs_if.sv | 48 ++++
 rtl/mem_stage_hs.sv | 192 +++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_hs_if.sv
// Bundle of every handshake and data signal around the Y86 memory-access stage:
// the execute-side input, the data-memory request/ack bus, and the write-back output.
// The "master" modport is the stage's own view; "slave" is the view of its surroundings.
interface mem_stage_hs_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  // execute side
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode_i;
  logic [WORD_W-1:0] valA_i;
  logic [WORD_W-1:0] valE_i;
  logic [WORD_W-1:0] valP_i;
  // data memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              mem_err;
  logic [WORD_W-1:0] mem_rdata;
  // write-back side
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        icode_o;
  logic [WORD_W-1:0] valE_o;
  logic [WORD_W-1:0] valM_o;
  logic [1:0]        stat_o;

  modport master (
    input  in_valid, icode_i, valA_i, valE_i, valP_i,
    input  mem_ack, mem_err, mem_rdata,
    input  out_ready,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output out_valid, icode_o, valE_o, valM_o, stat_o
  );

  modport slave (
    output in_valid, icode_i, valA_i, valE_i, valP_i,
    output mem_ack, mem_err, mem_rdata,
    output out_ready,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  out_valid, icode_o, valE_o, valM_o, stat_o
  );
endinterface

// File: rtl/mem_stage_hs.sv
// Y86 memory-access stage with valid/ready handshakes towards execute and
// write-back, and a req/ack handshake to data memory of arbitrary latency.
// One instruction is in flight at a time: IDLE -> (ACCESS) -> DONE -> IDLE.
module mem_stage_hs #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 16,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_hs_if.master        bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_ADR = 2'd1;
  localparam logic [1:0] STAT_TMO = 2'd2;

  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  // Byte-offset bits inside one word; a mask avoids a zero-width slice when WORD_W=8.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((WORD_W / 8) - 1);

  // Counter only has to reach TIMEOUT-1.
  localparam int                CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [3:0]        icode_q,  icode_d;
  logic [WORD_W-1:0] valE_q,   valE_d;
  logic [WORD_W-1:0] valM_q,   valM_d;
  logic [1:0]        stat_q,   stat_d;
  logic              we_q,     we_d;
  logic              rd_q,     rd_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [WORD_W-1:0] wdata_q,  wdata_d;

  logic              accept;
  logic              dec_wr;
  logic              dec_rd;
  logic [WORD_W-1:0] dec_word;
  logic [WORD_W-1:0] dec_wdata;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_misaligned;

  assign accept = bus.in_valid && (state_q == IDLE);

  // Decode the incoming icode into direction, address word and write data.
  always_comb begin
    dec_wr    = 1'b0;
    dec_rd    = 1'b0;
    dec_word  = '0;
    dec_wdata = '0;
    case (bus.icode_i)
      I_RMMOVL, I_PUSHL: begin
        dec_wr    = 1'b1;
        dec_word  = bus.valE_i;
        dec_wdata = bus.valA_i;
      end
      I_CALL: begin
        dec_wr    = 1'b1;
        dec_word  = bus.valE_i;
        dec_wdata = bus.valP_i;
      end
      I_MRMOVL: begin
        dec_rd    = 1'b1;
        dec_word  = bus.valE_i;
      end
      I_POPL, I_RET: begin
        dec_rd    = 1'b1;
        dec_word  = bus.valA_i;
      end
      default: ;
    endcase
    dec_addr       = ADDR_W'(dec_word);
    dec_misaligned = (CHECK_ALIGN != 0) && ((dec_addr & ALIGN_MASK) != '0);
  end

  // Next-state and datapath update for the IDLE/ACCESS/DONE controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    icode_d = icode_q;
    valE_d  = valE_q;
    valM_d  = valM_q;
    stat_d  = stat_q;
    we_d    = we_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          icode_d = bus.icode_i;
          valE_d  = bus.valE_i;
          valM_d  = '0;
          we_d    = dec_wr;
          rd_d    = dec_rd;
          addr_d  = dec_addr;
          wdata_d = dec_wdata;
          cnt_d   = '0;
          if (!(dec_wr || dec_rd)) begin
            state_d = DONE;
            stat_d  = STAT_AOK;
          end else if (dec_misaligned) begin
            state_d = DONE;
            stat_d  = STAT_ADR;
          end else begin
            state_d = ACCESS;
            stat_d  = STAT_AOK;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          state_d = DONE;
          if (bus.mem_err) begin
            stat_d = STAT_ADR;
            valM_d = '0;
          end else begin
            stat_d = STAT_AOK;
            valM_d = rd_q ? bus.mem_rdata : '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          // Give up; an ack arriving later lands in DONE/IDLE and is ignored.
          state_d = DONE;
          stat_d  = STAT_TMO;
          valM_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset clears everything so an in-flight request aborts at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      icode_q <= '0;
      valE_q  <= '0;
      valM_q  <= '0;
      stat_q  <= STAT_AOK;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
      valE_q  <= valE_d;
      valM_q  <= valM_d;
      stat_q  <= stat_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Handshake outputs come straight from the state register, so reset drops them asynchronously.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mem_req   = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.icode_o   = icode_q;
  assign bus.valE_o    = valE_q;
  assign bus.valM_o    = valM_q;
  assign bus.stat_o    = stat_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: table of instructions with hand-derived expectations,
// a scoreboard queue of expected write-back results, a reactive memory model,
// and hand-written sequences for the output stall, late ack and mid-access reset.
module tb_mem_stage_hs;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  mem_stage_hs_if #(.WORD_W(32), .ADDR_W(32)) ifc ();

  mem_stage_hs #(
    .WORD_W(32), .ADDR_W(32), .TIMEOUT(16), .CHECK_ALIGN(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [31:0] valA;
    logic [31:0] valE;
    logic [31:0] valP;
    int          ack_dly;   // ack on this request cycle; -1 = never
    logic        err;
    logic [31:0] rdata;
    int          hold;      // cycles out_ready stays low while out_valid
    bit          late_ack;  // drive mem_ack during the hold
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_valM;
    logic [1:0]  exp_stat;
    int          exp_lat;   // cycles from accept edge to out_valid
    int          exp_reqn;  // cycles mem_req is high
  } vec_t;

  typedef struct {
    logic [3:0]  icode;
    logic [31:0] valE;
    logic [31:0] valM;
    logic [1:0]  stat;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Runs one instruction starting at a negedge with the stage idle; ends at a negedge.
  task automatic run_vec(input vec_t v, input string nm);
    int   cyc;
    int   reqn;
    bit   got;
    exp_t e;
    exp_t a;
    chk({nm, ".in_ready"}, 128'(ifc.in_ready), 128'(1'b1));
    ifc.in_valid = 1'b1;
    ifc.icode_i  = v.icode;
    ifc.valA_i   = v.valA;
    ifc.valE_i   = v.valE;
    ifc.valP_i   = v.valP;
    e.icode = v.icode;
    e.valE  = v.valE;
    e.valM  = v.exp_valM;
    e.stat  = v.exp_stat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    cyc  = 0;
    reqn = 0;
    got  = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ifc.mem_ack = 1'b0;
      ifc.mem_err = 1'b0;
      if (ifc.out_valid) begin
        got = 1'b1;
      end else if (ifc.mem_req) begin
        reqn++;
        chk({nm, ".membus"}, 128'({ifc.mem_we, ifc.mem_addr, ifc.mem_wdata}),
            128'({v.exp_we, v.exp_addr, v.exp_wdata}));
        if (reqn == v.ack_dly) begin
          ifc.mem_ack   = 1'b1;
          ifc.mem_err   = v.err;
          ifc.mem_rdata = v.rdata;
        end
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s.timeout: got no out_valid within 40 cycles want out_valid", nm);
      exp_q.delete();
      return;
    end
    chk({nm, ".latency"}, 128'(cyc), 128'(v.exp_lat));
    chk({nm, ".req_cycles"}, 128'(reqn), 128'(v.exp_reqn));
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s.scoreboard: got empty queue want entry", nm);
      return;
    end
    a = exp_q.pop_front();
    chk({nm, ".icode_o"}, 128'(ifc.icode_o), 128'(a.icode));
    chk({nm, ".valE_o"},  128'(ifc.valE_o),  128'(a.valE));
    chk({nm, ".valM_o"},  128'(ifc.valM_o),  128'(a.valM));
    chk({nm, ".stat_o"},  128'(ifc.stat_o),  128'(a.stat));
    // Stall write-back; outputs must hold and no new accept may happen.
    for (int h = 0; h < v.hold; h++) begin
      if (v.late_ack) begin
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      chk({nm, ".hold"},
          128'({ifc.out_valid, ifc.in_ready, ifc.mem_req, ifc.icode_o, ifc.valE_o, ifc.valM_o, ifc.stat_o}),
          128'({1'b1, 1'b0, 1'b0, a.icode, a.valE, a.valM, a.stat}));
    end
    ifc.mem_ack   = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk({nm, ".release"}, 128'({ifc.out_valid, ifc.in_ready}), 128'({1'b0, 1'b1}));
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    //        icode  valA          valE         valP      ack err rdata         hold late we    addr         wdata         valM          stat  lat reqn
    tbl[0]  = '{4'h4, 32'h12345678, 32'h100,     32'h0,    3, 0, 32'h0,         0, 0, 1'b1, 32'h100,     32'h12345678, 32'h0,        2'd0, 4,  3};
    tbl[1]  = '{4'hB, 32'h200,      32'h204,     32'h0,    1, 0, 32'hCAFEBABE,  0, 0, 1'b0, 32'h200,     32'h0,        32'hCAFEBABE, 2'd0, 2,  1};
    tbl[2]  = '{4'h5, 32'h0,        32'h102,     32'h0,   -1, 0, 32'h0,         0, 0, 1'b0, 32'h0,       32'h0,        32'h0,        2'd1, 1,  0};
    tbl[3]  = '{4'h8, 32'h99,       32'h3FC,     32'h40,  -1, 0, 32'h0,         5, 1, 1'b1, 32'h3FC,     32'h40,       32'h0,        2'd2, 17, 16};
    tbl[4]  = '{4'h6, 32'h1111,     32'h55,      32'h0,   -1, 0, 32'h0,         5, 0, 1'b0, 32'h0,       32'h0,        32'h0,        2'd0, 1,  0};
    tbl[5]  = '{4'h5, 32'h0,        32'h300,     32'h0,    2, 1, 32'hDEADBEEF,  0, 0, 1'b0, 32'h300,     32'h0,        32'h0,        2'd1, 3,  2};
    tbl[6]  = '{4'h9, 32'h80,       32'h84,      32'h0,    1, 0, 32'h1234,      0, 0, 1'b0, 32'h80,      32'h0,        32'h1234,     2'd0, 2,  1};
    tbl[7]  = '{4'hA, 32'hDEAD,     32'h7FC,     32'h0,    2, 0, 32'h0,         0, 0, 1'b1, 32'h7FC,     32'hDEAD,     32'h0,        2'd0, 3,  2};
    tbl[8]  = '{4'h8, 32'h0,        32'h3FE,     32'h40,  -1, 0, 32'h0,         0, 0, 1'b0, 32'h0,       32'h0,        32'h0,        2'd1, 1,  0};
    tbl[9]  = '{4'h1, 32'h0,        32'h0,       32'h0,   -1, 0, 32'h0,         0, 0, 1'b0, 32'h0,       32'h0,        32'h0,        2'd0, 1,  0};
    tbl[10] = '{4'h5, 32'h0,        32'h40,      32'h0,    1, 0, 32'h11,        1, 0, 1'b0, 32'h40,      32'h0,        32'h11,       2'd0, 2,  1};

    rst           = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.icode_i   = 4'h0;
    ifc.valA_i    = 32'h0;
    ifc.valE_i    = 32'h0;
    ifc.valP_i    = 32'h0;
    ifc.mem_ack   = 1'b0;
    ifc.mem_err   = 1'b0;
    ifc.mem_rdata = 32'h0;
    ifc.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset.ctrl", 128'({ifc.in_ready, ifc.mem_req, ifc.mem_we, ifc.out_valid}),
        128'({1'b1, 1'b0, 1'b0, 1'b0}));
    chk("reset.data", 128'({ifc.icode_o, ifc.valE_o, ifc.valM_o, ifc.stat_o, ifc.mem_addr}),
        128'({4'h0, 32'h0, 32'h0, 2'd0, 32'h0}));
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset pulled in the middle of a write access.
    ifc.in_valid = 1'b1;
    ifc.icode_i  = 4'h4;
    ifc.valA_i   = 32'hAAAA5555;
    ifc.valE_i   = 32'h500;
    ifc.valP_i   = 32'h0;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.req_before", 128'({ifc.mem_req, ifc.mem_we, ifc.mem_addr}),
        128'({1'b1, 1'b1, 32'h500}));
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid.async", 128'({ifc.mem_req, ifc.mem_we, ifc.out_valid, ifc.stat_o, ifc.icode_o, ifc.mem_wdata}),
        128'({1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.idle_after", 128'({ifc.in_ready, ifc.mem_req, ifc.out_valid}),
        128'({1'b1, 1'b0, 1'b0}));
    rv = tbl[0];
    rv.valA      = 32'h0BADF00D;
    rv.exp_wdata = 32'h0BADF00D;
    rv.ack_dly   = 1;
    rv.exp_lat   = 2;
    rv.exp_reqn  = 1;
    run_vec(rv, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
